// File: rtl/subtractor_34_seq.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB first.
// Define SUB34_ZERO_FLAG_EN to add the registered zero-result output.
module subtractor_34_seq #(
  parameter int WIDTH = 34,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB34_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic [BW-1:0]    w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sub;
  logic [WIDTH-1:0] w_part_next;
  logic             w_last;
  logic             w_accept;

  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_count == CW'(N - 1));

  // The extra top bit of the chunk subtraction is the borrow into the next chunk.
  always_comb begin
    w_base      = BW'(r_count) * BW'(CHUNK);
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_chunk_sub = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
    w_part_next = r_part;
    w_part_next[w_base +: CHUNK] = w_chunk_sub[CHUNK-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
`ifdef SUB34_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_part   <= '0;
      r_count  <= '0;
    end else if (r_state == S_BUSY) begin
      r_part   <= w_part_next;
      r_borrow <= w_chunk_sub[CHUNK];
      r_count  <= r_count + CW'(1);
      // Visible results change only on the edge that enters DONE.
      if (w_last) begin
        diff     <= w_part_next;
        bout     <= w_chunk_sub[CHUNK];
        overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_part_next[WIDTH-1] != r_a[WIDTH-1]);
`ifdef SUB34_ZERO_FLAG_EN
        zero     <= (w_part_next == '0);
`endif
      end
    end
  end

endmodule
